// File: rtl/viterbi_pkg.sv
// rtl/viterbi_pkg.sv - shared state encoding, PRBS-7 constants and counter helpers
package viterbi_pkg;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_RUN   = 3'd1,
        ST_TAIL  = 3'd2,
        ST_DRAIN = 3'd3,
        ST_DONE  = 3'd4
    } state_e;

    // PRBS-7, x^7 + x^6 + 1, MSB is the output bit
    localparam logic [6:0]  PRBS_SEED = 7'h7F;
    localparam logic [6:0]  PRBS_TAPS = 7'b110_0000;
    localparam logic [15:0] CT_MAX    = 16'hFFFF;

    function automatic logic [6:0] prbs_next(input logic [6:0] s);
        return {s[5:0], ^(s & PRBS_TAPS)};
    endfunction

    function automatic logic [15:0] sat_inc(input logic [15:0] v);
        return (v == CT_MAX) ? v : v + 16'd1;
    endfunction

endpackage

// File: rtl/viterbi_ref_delay.sv
// rtl/viterbi_ref_delay.sv - DEPTH-stage clear-on-reset delay line
module viterbi_ref_delay #(
    parameter int DEPTH = 16,
    parameter int WIDTH = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] i_data,
    output logic [WIDTH-1:0] o_data
);

    generate
        if (DEPTH == 0) begin : g_pass
            assign o_data = i_data;
        end else begin : g_dly
            logic [WIDTH-1:0] r_pipe [DEPTH];

            always_ff @(posedge clk) begin
                if (rst) begin
                    for (int i = 0; i < DEPTH; i++) begin
                        r_pipe[i] <= '0;
                    end
                end else begin
                    r_pipe[0] <= i_data;
                    for (int i = 1; i < DEPTH; i++) begin
                        r_pipe[i] <= r_pipe[i-1];
                    end
                end
            end

            assign o_data = r_pipe[DEPTH-1];
        end
    endgenerate

endmodule

// File: rtl/viterbi_ber_ctrl.sv
// rtl/viterbi_ber_ctrl.sv - frame sequencer, channel error injector and BER counter
module viterbi_ber_ctrl
    import viterbi_pkg::*;
#(
    parameter int DEC_LAT  = 16,
    parameter int ENC_LAT  = 1,
    parameter int TAIL_LEN = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start_i,
    input  logic [15:0] frame_len_i,
    input  logic [7:0]  err_period_i,
    input  logic [3:0]  burst_len_i,
    input  logic [1:0]  err_bits_i,
    output logic        enc_en_o,
    output logic        enc_bit_o,
    output logic [1:0]  err_mask_o,
    input  logic        dec_bit_i,
    output logic        busy_o,
    output logic        done_o,
    output logic [15:0] bit_err_ct_o,
    output logic [15:0] inj_ct_o
);

    state_e      r_state;
    logic [15:0] r_frame_len;
    logic [7:0]  r_err_period;
    logic [3:0]  r_burst_len;
    logic [1:0]  r_err_bits;
    logic [6:0]  r_prbs;
    logic [15:0] r_bit_ct;
    logic [15:0] r_tail_ct;
    logic [15:0] r_cmp_ct;
    logic [7:0]  r_word_ct;
    logic [15:0] r_bit_err_ct;
    logic [15:0] r_inj_ct;
    logic        r_done;

    logic        w_start;
    logic        w_enc_en;
    logic        w_enc_bit;
    logic        w_pay_en;
    logic        w_strobe;
    logic        w_ref_en;
    logic        w_ref_bit;
    logic [1:0]  w_ref_data;
    logic        w_word_hit;
    logic [1:0]  w_mask;

    assign w_start   = (r_state == ST_IDLE) && start_i;
    assign w_enc_en  = (r_state == ST_RUN) || (r_state == ST_TAIL);
    assign w_pay_en  = (r_state == ST_RUN);
    assign w_enc_bit = w_pay_en & r_prbs[6];

    // Word strobe: encoder enable as seen at the channel
    viterbi_ref_delay #(
        .DEPTH (ENC_LAT),
        .WIDTH (1)
    ) u_strobe_dly (
        .clk    (clk),
        .rst    (rst),
        .i_data (w_enc_en),
        .o_data (w_strobe)
    );

    // Reference bit and payload-only enable aligned to the decoder output
    viterbi_ref_delay #(
        .DEPTH (DEC_LAT),
        .WIDTH (2)
    ) u_ref_dly (
        .clk    (clk),
        .rst    (rst),
        .i_data ({w_pay_en, w_enc_bit}),
        .o_data (w_ref_data)
    );

    assign w_ref_en  = w_ref_data[1];
    assign w_ref_bit = w_ref_data[0];

    // Burst sits at the end of each period; a burst no shorter than the period hits every word
    assign w_word_hit = ({4'b0000, r_burst_len} >= r_err_period) ||
                        (r_word_ct >= (r_err_period - {4'b0000, r_burst_len}));

    assign w_mask = (w_strobe && (r_err_period != 8'd0) && (r_err_bits != 2'b00) && w_word_hit)
                    ? r_err_bits : 2'b00;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state      <= ST_IDLE;
            r_frame_len  <= 16'd0;
            r_err_period <= 8'd0;
            r_burst_len  <= 4'd0;
            r_err_bits   <= 2'b00;
            r_prbs       <= PRBS_SEED;
            r_bit_ct     <= 16'd0;
            r_tail_ct    <= 16'd0;
            r_done       <= 1'b0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (start_i) begin
                        r_frame_len  <= frame_len_i;
                        r_err_period <= err_period_i;
                        r_burst_len  <= burst_len_i;
                        r_err_bits   <= err_bits_i;
                        r_prbs       <= PRBS_SEED;
                        r_bit_ct     <= 16'd0;
                        r_tail_ct    <= 16'd0;
                        r_state      <= (frame_len_i == 16'd0) ? ST_DONE : ST_RUN;
                    end
                end
                ST_RUN: begin
                    r_prbs   <= prbs_next(r_prbs);
                    r_bit_ct <= r_bit_ct + 16'd1;
                    if (r_bit_ct == r_frame_len - 16'd1) begin
                        r_state <= (TAIL_LEN == 0) ? ST_DRAIN : ST_TAIL;
                    end
                end
                ST_TAIL: begin
                    r_tail_ct <= r_tail_ct + 16'd1;
                    if (r_tail_ct == 16'(TAIL_LEN - 1)) begin
                        r_state <= ST_DRAIN;
                    end
                end
                ST_DRAIN: begin
                    if (r_cmp_ct == r_frame_len) begin
                        r_state <= ST_DONE;
                    end
                end
                ST_DONE: begin
                    r_done  <= 1'b1;
                    r_state <= ST_IDLE;
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst || w_start) begin
            r_word_ct    <= 8'd0;
            r_cmp_ct     <= 16'd0;
            r_bit_err_ct <= 16'd0;
            r_inj_ct     <= 16'd0;
        end else begin
            if (w_strobe) begin
                if ((r_err_period == 8'd0) || (r_word_ct == r_err_period - 8'd1)) begin
                    r_word_ct <= 8'd0;
                end else begin
                    r_word_ct <= r_word_ct + 8'd1;
                end
            end
            if (w_mask != 2'b00) begin
                r_inj_ct <= sat_inc(r_inj_ct);
            end
            if (w_ref_en) begin
                r_cmp_ct <= r_cmp_ct + 16'd1;
                if (dec_bit_i != w_ref_bit) begin
                    r_bit_err_ct <= sat_inc(r_bit_err_ct);
                end
            end
        end
    end

    assign enc_en_o     = w_enc_en;
    assign enc_bit_o    = w_enc_bit;
    assign err_mask_o   = w_mask;
    assign busy_o       = (r_state != ST_IDLE);
    assign done_o       = r_done;
    assign bit_err_ct_o = r_bit_err_ct;
    assign inj_ct_o     = r_inj_ct;

endmodule
